// File: rtl/mic_capture_ctrl.sv
// Periodic microphone sample capture: a period timer triggers one 16-bit SPI read,
// and the result is pushed into a sample FIFO with sticky error flags.
`timescale 1ns/1ps
module mic_capture_ctrl #(
    parameter int PERIOD     = 256,
    parameter int CS_TIMEOUT = 16
) (
    input  logic        sysclk,
    input  logic        PRESETn,
    input  logic        enable,
    output logic        spi_start,
    input  logic        spi_cs_b,
    input  logic [15:0] spi_data,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_wr_data,
    input  logic        fifo_full,
    input  logic        clr_flags,
    output logic        busy,
    output logic        ovf_flag,
    output logic        overrun_flag,
    output logic        timeout_flag,
    output logic [15:0] sample_cnt
);

    localparam logic [15:0] RELOAD = 16'(PERIOD - 1);
    localparam int          TW     = $clog2(CS_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(CS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_PUSH
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_period_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          w_tick;

    logic          r_spi_start;
    logic          r_fifo_wr_en;
    logic [15:0]   r_fifo_wr_data;
    logic          r_busy;
    logic          r_ovf_flag;
    logic          r_overrun_flag;
    logic          r_timeout_flag;
    logic [15:0]   r_sample_cnt;

    logic          w_spi_start_nxt;
    logic          w_busy_nxt;
    logic          w_wr_en_nxt;
    logic          w_latch;
    logic          w_set_to;
    logic          w_set_ovr;
    logic          w_set_ovf;
    logic          w_cnt_inc;

    assign w_tick = enable && (r_period_cnt == '0);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge sysclk or negedge PRESETn) begin
        if (!PRESETn) begin
            r_period_cnt <= RELOAD;
        end else if (!enable || w_tick) begin
            r_period_cnt <= RELOAD;
        end else begin
            r_period_cnt <= r_period_cnt - 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:      if (w_tick) w_state_nxt = S_START;
            S_START:     w_state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!spi_cs_b) begin
                    w_state_nxt = S_WAIT_HIGH;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_HIGH: if (spi_cs_b) w_state_nxt = S_PUSH;
            S_PUSH:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, so the write decision samples fifo_full in the cycle that
    // enters PUSH; the strobe and the counter/ovf update then agree on one decision.
    always_comb begin
        w_spi_start_nxt = (w_state_nxt == S_START);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_latch         = (r_state == S_WAIT_HIGH) && spi_cs_b;
        w_wr_en_nxt     = w_latch && !fifo_full;
        w_set_to        = (r_state == S_WAIT_LOW) && spi_cs_b && (r_to_cnt == TO_LAST);
        w_set_ovr       = w_tick && (r_state != S_IDLE);
        w_set_ovf       = (r_state == S_PUSH) && !r_fifo_wr_en;
        w_cnt_inc       = (r_state == S_PUSH) && r_fifo_wr_en;
    end

    always_ff @(posedge sysclk or negedge PRESETn) begin
        if (!PRESETn) begin
            r_to_cnt <= '0;
        end else if (r_state == S_START) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_WAIT_LOW) && spi_cs_b && (r_to_cnt != TO_LAST)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge PRESETn) begin
        if (!PRESETn) begin
            r_spi_start    <= 1'b0;
            r_fifo_wr_en   <= 1'b0;
            r_fifo_wr_data <= 16'h0000;
            r_busy         <= 1'b0;
            r_ovf_flag     <= 1'b0;
            r_overrun_flag <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_sample_cnt   <= 16'h0000;
        end else begin
            r_spi_start    <= w_spi_start_nxt;
            r_fifo_wr_en   <= w_wr_en_nxt;
            r_busy         <= w_busy_nxt;
            if (w_latch) begin
                r_fifo_wr_data <= spi_data;
            end
            // Set has priority over a simultaneous clear.
            r_ovf_flag     <= w_set_ovf | (r_ovf_flag & ~clr_flags);
            r_overrun_flag <= w_set_ovr | (r_overrun_flag & ~clr_flags);
            r_timeout_flag <= w_set_to  | (r_timeout_flag & ~clr_flags);
            if (w_cnt_inc) begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
        end
    end

    assign spi_start    = r_spi_start;
    assign fifo_wr_en   = r_fifo_wr_en;
    assign fifo_wr_data = r_fifo_wr_data;
    assign busy         = r_busy;
    assign ovf_flag     = r_ovf_flag;
    assign overrun_flag = r_overrun_flag;
    assign timeout_flag = r_timeout_flag;
    assign sample_cnt   = r_sample_cnt;

endmodule

// File: doc/mic_capture_ctrl.md
MIC_CAPTURE_CTRL -- requirements
Module: mic_capture_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 256: sysclk cycles between sample triggers; legal range 64..65535.
REQ-002 SHALL have parameter CS_TIMEOUT, default 16: max sysclk cycles from spi_start until spi_cs_b low.
REQ-003 SHALL have port sysclk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  level; 1 = periodic capture running.
REQ-006 SHALL have port spi_start  output  1  one-cycle pulse that starts one 16-bit SPI read.
REQ-007 SHALL have port spi_cs_b  input  1  SPI engine chip select; low while a read is in progress.
REQ-008 SHALL have port spi_data  input  16  SPI engine result; valid once spi_cs_b returns high.
REQ-009 SHALL have port fifo_wr_en  output  1  one-cycle write strobe to the sample FIFO.
REQ-010 SHALL have port fifo_wr_data  output  16  registered sample; valid when fifo_wr_en=1.
REQ-011 SHALL have port fifo_full  input  1  FIFO cannot accept a write this cycle.
REQ-012 SHALL have port clr_flags  input  1  one-cycle pulse; clears all sticky flags.
REQ-013 SHALL have port busy  output  1  1 in any state other than IDLE.
REQ-014 SHALL have port ovf_flag  output  1  sticky; a sample was dropped because of fifo_full.
REQ-015 SHALL have port overrun_flag  output  1  sticky; a tick fired while busy.
REQ-016 SHALL have port timeout_flag  output  1  sticky; spi_cs_b did not go low within CS_TIMEOUT.
REQ-017 SHALL have port sample_cnt  output  16  count of samples written to the FIFO; wraps 0xFFFF->0x0000.

Function
REQ-018 The period counter SHALL hold PERIOD-1 while enable=0, and decrement once per cycle while enable=1.
REQ-019 When the period counter is 0 with enable=1, it SHALL assert an internal tick and reload PERIOD-1 on the next cycle; the first tick occurs PERIOD cycles after enable rises.
REQ-020 The FSM SHALL have states IDLE, START, WAIT_LOW, WAIT_HIGH and PUSH.
REQ-021 IDLE: on a tick, the FSM SHALL go to START; otherwise it SHALL stay in IDLE.
REQ-022 START: spi_start SHALL be 1 for exactly this one cycle; the FSM SHALL then go to WAIT_LOW and clear the timeout counter.
REQ-023 WAIT_LOW: on spi_cs_b=0 the FSM SHALL go to WAIT_HIGH; after CS_TIMEOUT cycles with spi_cs_b=1 it SHALL set timeout_flag and go to IDLE.
REQ-024 WAIT_HIGH: on the first cycle with spi_cs_b=1, the block SHALL latch spi_data into fifo_wr_data and go to PUSH.
REQ-025 PUSH: if fifo_full=0, fifo_wr_en SHALL be 1 for this cycle and sample_cnt SHALL increment; if fifo_full=1, fifo_wr_en SHALL stay 0 and ovf_flag SHALL be set. Either way the FSM SHALL go to IDLE.
REQ-026 Latency SHALL be: tick in cycle N -> spi_start in N+1; spi_cs_b seen high in WAIT_HIGH at cycle M -> fifo_wr_en in M+1.
REQ-027 A tick in any state other than IDLE SHALL set overrun_flag and be discarded; ticks are not queued.
REQ-028 enable falling mid-capture SHALL NOT abort the capture; it completes through PUSH, and no further ticks occur.
REQ-029 If clr_flags and a flag-set event occur in the same cycle, the set SHALL win.
REQ-030 spi_cs_b and spi_data SHALL be treated as synchronous to sysclk; no synchronizers.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While PRESETn=0, the block SHALL force: FSM=IDLE, period counter=PERIOD-1, spi_start=0, fifo_wr_en=0, fifo_wr_data=0x0000, busy=0, all flags=0, sample_cnt=0x0000.
REQ-033 Reset asserted mid-capture SHALL abandon the capture with no FIFO write; after PRESETn rises, the first tick SHALL occur PERIOD cycles after enable=1 is observed.

Verification
REQ-034 Basic: enable=1, SPI model returns 0xA5C3, fifo_full=0 -> spi_start at cycle 256; exactly one fifo_wr_en with fifo_wr_data=0xA5C3; sample_cnt=1.
REQ-035 Periodic: run 10 periods -> exactly 10 spi_start pulses spaced 256 cycles apart; sample_cnt=10; no flags set.
REQ-036 FIFO full: hold fifo_full=1 during PUSH -> no fifo_wr_en; ovf_flag=1; sample_cnt unchanged. Then pulse clr_flags -> ovf_flag=0.
REQ-037 Timeout: SPI model never drops spi_cs_b -> timeout_flag=1 exactly 16 cycles after WAIT_LOW is entered; FSM back in IDLE; next tick starts a new capture.
REQ-038 Overrun: SPI model holds spi_cs_b low for 300 cycles -> overrun_flag=1; the tick that fired while busy produces no extra spi_start.
REQ-039 Reset and wrap: assert PRESETn=0 during WAIT_HIGH -> all outputs at reset values, no write; separately, force sample_cnt=0xFFFF and complete one capture -> sample_cnt=0x0000.
